// File: rtl/fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO family.
// Width helpers and the depth legality check are used by sync_fifo_param.
package fifo_pkg;

  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  // Pointer/count types for the default 16-entry configuration.
  typedef logic [width_for(16)-1:0]     ptr16_t;
  typedef logic [width_for(16 + 1)-1:0] cnt16_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register array: one write port, one registered read port.
// The read register clears on reset so in-flight reads are discarded.
module fifo_mem_2p #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int PTR_W = fifo_pkg::width_for(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-edge write to raddr (full with read+write) returns the old entry.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with almost flags, read-valid strobe and
// sticky overflow/underflow. All status is decoded from registered state.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int PTR_W   = width_for(DEPTH),
  localparam int CNT_W   = width_for(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam bit DEPTH_OK = is_pow2(DEPTH);

  if (!DEPTH_OK) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // Writing while full is legal only alongside an accepted read.
  assign wr_acc = w_en & (~full | r_en);
  assign rd_acc = r_en & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      rd_valid  <= rd_acc;
      overflow  <= overflow  | (w_en & ~wr_acc);
      underflow <= underflow | (r_en & empty);
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          w_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          rd_valid, empty, full, almost_empty, almost_full;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  logic [31:0] m_dout;
  bit          m_rdv, m_ovf, m_unf;

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] d;
    int          cnt;
    bit          rdv;
    logic [31:0] dout;
    bit          unf;
  } vec_t;

  vec_t vecs[8];

  sync_fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("m_count",     32'(count),        32'(n));
    chk("m_empty",     32'(empty),        32'(n == 0));
    chk("m_full",      32'(full),         32'(n == DEPTH));
    chk("m_alm_empty", 32'(almost_empty), 32'(n <= AE));
    chk("m_alm_full",  32'(almost_full),  32'(n >= AF));
    chk("m_rd_valid",  32'(rd_valid),     32'(m_rdv));
    chk("m_data_out",  data_out,          m_dout);
    chk("m_overflow",  32'(overflow),     32'(m_ovf));
    chk("m_underflow", 32'(underflow),    32'(m_unf));
  endtask

  // Drive one cycle, advance the reference model, then check after the edge.
  task automatic step(input bit rst, input bit w, input logic [31:0] d, input bit r);
    bit full_m, empty_m, wacc, racc;
    @(negedge clk);
    reset = rst; w_en = w; data_in = d; r_en = r;
    if (rst) begin
      q.delete();
      m_dout = '0; m_rdv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      full_m  = (q.size() == DEPTH);
      empty_m = (q.size() == 0);
      wacc    = w && (!full_m || r);
      racc    = r && !empty_m;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
      m_rdv = racc;
      if (w && !wacc) m_ovf = 1;
      if (r && empty_m) m_unf = 1;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) step(0, 1, base + 32'(k), 0);
  endtask

  initial begin
    int wp, rp;
    logic [31:0] exp_d;

    vecs[0] = '{1, 1, 32'h55, 1, 0, 32'h00, 1};
    vecs[1] = '{0, 1, 32'h00, 0, 1, 32'h55, 1};
    vecs[2] = '{1, 0, 32'h11, 1, 0, 32'h55, 1};
    vecs[3] = '{1, 0, 32'h22, 2, 0, 32'h55, 1};
    vecs[4] = '{1, 1, 32'h33, 2, 1, 32'h11, 1};
    vecs[5] = '{0, 1, 32'h00, 1, 1, 32'h22, 1};
    vecs[6] = '{0, 1, 32'h00, 0, 1, 32'h33, 1};
    vecs[7] = '{0, 1, 32'h00, 0, 0, 32'h33, 1};

    // Reset state and idle
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      chk("rst_empty",  32'(empty),        32'd1);
      chk("rst_full",   32'(full),         32'd0);
      chk("rst_ae",     32'(almost_empty), 32'd1);
      chk("rst_af",     32'(almost_full),  32'd0);
      chk("rst_count",  32'(count),        32'd0);
      chk("rst_dout",   data_out,          32'd0);
      chk("rst_rdv",    32'(rd_valid),     32'd0);
      chk("rst_ovf",    32'(overflow),     32'd0);
      chk("rst_unf",    32'(underflow),    32'd0);
    end

    // Vector table: read/write on empty and simple sequences
    for (int i = 0; i < 8; i++) begin
      step(0, vecs[i].w, vecs[i].d, vecs[i].r);
      chk($sformatf("tbl%0d_count", i), 32'(count),     32'(vecs[i].cnt));
      chk($sformatf("tbl%0d_rdv", i),   32'(rd_valid),  32'(vecs[i].rdv));
      chk($sformatf("tbl%0d_dout", i),  data_out,       vecs[i].dout);
      chk($sformatf("tbl%0d_unf", i),   32'(underflow), 32'(vecs[i].unf));
    end

    // Fill to full, almost_full boundary, overflow, drain in order
    step(1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 32'(k), 0);
      if (k == 13) chk("af_at_13",   32'(almost_full), 32'd0);
      if (k == 14) chk("af_at_14",   32'(almost_full), 32'd1);
      if (k == 15) chk("full_at_15", 32'(full),        32'd0);
      if (k == 16) chk("full_at_16", 32'(full),        32'd1);
    end
    step(0, 1, 32'hDEAD, 0);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd16);
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0, 1);
      chk("drain_full", data_out, 32'(k));
      chk("drain_rdv",  32'(rd_valid), 32'd1);
    end

    // Simultaneous read+write while full
    step(1, 0, 0, 0);
    fill(16, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 32'hA0 + 32'(k), 1);
      chk("rw_full_count", 32'(count),    32'd16);
      chk("rw_full_full",  32'(full),     32'd1);
      chk("rw_full_ovf",   32'(overflow), 32'd0);
    end
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 1);
      exp_d = (k < 12) ? 32'(k + 5) : 32'hA0 + 32'(k - 12);
      chk("rw_full_drain", data_out, exp_d);
    end

    // Steady 1:1 traffic over pointer wrap with 8 prefilled
    step(1, 0, 0, 0);
    fill(8, 32'd100);
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 32'd200 + 32'(k), 1);
      exp_d = (k < 8) ? 32'd100 + 32'(k) : 32'd200 + 32'(k - 8);
      chk("wrap_data",  data_out,    exp_d);
      chk("wrap_count", 32'(count),  32'd8);
    end

    // Reset on the same edge as a read, with both sticky flags set
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    fill(16, 32'd300);
    step(0, 1, 32'd999, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rstrd_rdv",   32'(rd_valid),  32'd0);
    chk("rstrd_count", 32'(count),     32'd0);
    chk("rstrd_empty", 32'(empty),     32'd1);
    chk("rstrd_ovf",   32'(overflow),  32'd0);
    chk("rstrd_unf",   32'(underflow), 32'd0);

    // Randomized traffic in phases of varying read/write pressure
    for (int ph = 0; ph < 6; ph++) begin
      wp = $urandom_range(90, 10);
      rp = $urandom_range(90, 10);
      for (int k = 0; k < 500; k++) begin
        step(($urandom_range(399) == 0),
             ($urandom_range(99) < wp),
             $urandom,
             ($urandom_range(99) < rp));
      end
    end

    @(negedge clk);
    w_en = 0; r_en = 0; reset = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
